coef_zigzag_rle: RTL and testbench

Entropy-front stage placed directly downstream of the HLPTE engine. It consumes the signed 32-bit quantized coefficient stream HLPTE emits on `out_valid`/`out_value`, in raster order, 16 per 4x4 block. It re-orders each block into H.264 4x4 zigzag order and emits (run, level) pairs for the nonzero coefficients, with the final pair of each block flagged. Two ping-pong banks absorb back-to-back blocks without any upstream stall.

---
 rtl/coef_zigzag_rle.sv | 198 +++++++++++++++++++
 tb/tb_coef_zigzag_rle.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/coef_zigzag_rle.sv
// +----------------------------------------------------------------------------+
// | coef_zigzag_rle: 4x4 raster coefficients -> zigzag (run, level) pairs with   |
// | ping-pong banks so back-to-back blocks never stall the producer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module coef_zigzag_rle #(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [31:0]        in_coef,
  output logic                      out_valid,
  output logic [3:0]                out_run,
  output logic signed [LEVEL_W-1:0] out_level,
  output logic                      out_last,
  output logic                      out_sat
);

  localparam logic signed [31:0] c_lvl_max = (32'sd1 <<< (LEVEL_W - 1)) - 32'sd1;
  localparam logic signed [31:0] c_lvl_min = -(32'sd1 <<< (LEVEL_W - 1));

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  function automatic logic [3:0] zz_to_raster(input logic [3:0] p);
    case (p)
      4'd0:  zz_to_raster = 4'd0;
      4'd1:  zz_to_raster = 4'd1;
      4'd2:  zz_to_raster = 4'd4;
      4'd3:  zz_to_raster = 4'd8;
      4'd4:  zz_to_raster = 4'd5;
      4'd5:  zz_to_raster = 4'd2;
      4'd6:  zz_to_raster = 4'd3;
      4'd7:  zz_to_raster = 4'd6;
      4'd8:  zz_to_raster = 4'd9;
      4'd9:  zz_to_raster = 4'd12;
      4'd10: zz_to_raster = 4'd13;
      4'd11: zz_to_raster = 4'd10;
      4'd12: zz_to_raster = 4'd7;
      4'd13: zz_to_raster = 4'd11;
      4'd14: zz_to_raster = 4'd14;
      default: zz_to_raster = 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] raster_to_zz(input logic [3:0] r);
    case (r)
      4'd0:  raster_to_zz = 4'd0;
      4'd1:  raster_to_zz = 4'd1;
      4'd2:  raster_to_zz = 4'd5;
      4'd3:  raster_to_zz = 4'd6;
      4'd4:  raster_to_zz = 4'd2;
      4'd5:  raster_to_zz = 4'd4;
      4'd6:  raster_to_zz = 4'd7;
      4'd7:  raster_to_zz = 4'd12;
      4'd8:  raster_to_zz = 4'd3;
      4'd9:  raster_to_zz = 4'd8;
      4'd10: raster_to_zz = 4'd11;
      4'd11: raster_to_zz = 4'd13;
      4'd12: raster_to_zz = 4'd9;
      4'd13: raster_to_zz = 4'd10;
      4'd14: raster_to_zz = 4'd14;
      default: raster_to_zz = 4'd15;
    endcase
  endfunction

  // Fill side
  logic [3:0]         r_beat;
  logic               r_fill_bank;
  logic [3:0]         r_last_nz [2];
  logic [1:0]         r_any_nz;
  logic signed [31:0] r_mem [2][16];

  logic       w_complete;
  logic [3:0] w_beat_zz;
  logic       w_beat_nz;

  assign w_complete = in_valid && (r_beat == 4'd15);
  assign w_beat_zz  = raster_to_zz(r_beat);
  assign w_beat_nz  = (in_coef != 32'sd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat       <= 4'd0;
      r_fill_bank  <= 1'b0;
      r_last_nz[0] <= 4'd0;
      r_last_nz[1] <= 4'd0;
      r_any_nz     <= 2'b00;
    end else if (in_valid) begin
      r_beat <= r_beat + 4'd1;
      // Beat 0 re-initialises the bank's tracking, so stale data never leaks in.
      if (r_beat == 4'd0) begin
        r_last_nz[r_fill_bank] <= w_beat_nz ? w_beat_zz : 4'd0;
        r_any_nz[r_fill_bank]  <= w_beat_nz;
      end else if (w_beat_nz) begin
        r_any_nz[r_fill_bank] <= 1'b1;
        if (!r_any_nz[r_fill_bank] || (w_beat_zz > r_last_nz[r_fill_bank]))
          r_last_nz[r_fill_bank] <= w_beat_zz;
      end
      if (w_complete)
        r_fill_bank <= ~r_fill_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid)
      r_mem[r_fill_bank][r_beat] <= in_coef;
  end

  // Drain side
  state_t     r_state;
  logic       r_scan_bank;
  logic [3:0] r_pos;
  logic [3:0] r_run;
  logic [1:0] r_full;

  logic signed [31:0]        w_coef;
  logic                      w_is_last;
  logic                      w_all_zero;
  logic                      w_emit;
  logic                      w_clip_hi;
  logic                      w_clip_lo;
  logic signed [LEVEL_W-1:0] w_level;
  logic                      w_other_ready;
  logic                      w_idle_bank;

  assign w_coef      = r_mem[r_scan_bank][zz_to_raster(r_pos)];
  assign w_is_last   = (r_pos == r_last_nz[r_scan_bank]);
  assign w_all_zero  = !r_any_nz[r_scan_bank];
  assign w_emit      = w_all_zero || (w_coef != 32'sd0);
  assign w_clip_hi   = (w_coef > c_lvl_max);
  assign w_clip_lo   = (w_coef < c_lvl_min);
  assign w_level     = w_clip_hi ? c_lvl_max[LEVEL_W-1:0] :
                       w_clip_lo ? c_lvl_min[LEVEL_W-1:0] : w_coef[LEVEL_W-1:0];
  // A bank completing this very cycle counts as ready: its data lands at this edge.
  assign w_other_ready = r_full[~r_scan_bank] || (w_complete && (r_fill_bank != r_scan_bank));
  assign w_idle_bank   = r_full[0] ? 1'b0 : r_full[1] ? 1'b1 : r_fill_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_scan_bank <= 1'b0;
      r_pos       <= 4'd0;
      r_run       <= 4'd0;
      r_full      <= 2'b00;
      out_valid   <= 1'b0;
      out_run     <= 4'd0;
      out_level   <= '0;
      out_last    <= 1'b0;
      out_sat     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      if (w_complete)
        r_full[r_fill_bank] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if ((r_full != 2'b00) || w_complete) begin
            r_state     <= S_SCAN;
            r_scan_bank <= w_idle_bank;
            r_pos       <= 4'd0;
            r_run       <= 4'd0;
          end
        end
        S_SCAN: begin
          if (w_emit) begin
            out_valid <= 1'b1;
            out_run   <= r_run;
            out_level <= w_level;
            out_sat   <= w_clip_hi || w_clip_lo;
            out_last  <= w_is_last;
            r_run     <= 4'd0;
          end else begin
            r_run <= r_run + 4'd1;
          end
          if (w_is_last) begin
            r_full[r_scan_bank] <= 1'b0;
            r_pos               <= 4'd0;
            r_run               <= 4'd0;
            if (w_other_ready)
              r_scan_bank <= ~r_scan_bank;
            else
              r_state <= S_IDLE;
          end else begin
            r_pos <= r_pos + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coef_zigzag_rle.sv
// +----------------------------------------------------------------------------+
// | tb_coef_zigzag_rle: directed scoreboard bench for coef_zigzag_rle.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_coef_zigzag_rle;

  localparam int LEVEL_W = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic signed [31:0]        in_coef = 32'sd0;
  logic                      out_valid;
  logic [3:0]                out_run;
  logic signed [LEVEL_W-1:0] out_level;
  logic                      out_last;
  logic                      out_sat;

  coef_zigzag_rle #(.LEVEL_W(LEVEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_run   (out_run),
    .out_level (out_level),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [3:0]         run;
    logic signed [15:0] level;
    logic               last;
    logic               sat;
  } pair_t;

  pair_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    fill_cnt = 0;
  int    drain_free = -100;
  int    blk[16];
  int    cur[16];
  int    zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  // Reference: expected pairs of a completed block, timed from its 16th beat.
  task automatic schedule(input int c0);
    int start, lastnz, run, v;
    pair_t e;
    start  = (c0 + 1 > drain_free + 1) ? c0 + 1 : drain_free + 1;
    lastnz = -1;
    for (int p = 0; p < 16; p++)
      if (blk[zz[p]] != 0) lastnz = p;
    if (lastnz < 0) begin
      e.cyc = start + 1; e.run = 4'd0; e.level = 16'sd0; e.last = 1'b1; e.sat = 1'b0;
      q.push_back(e);
      drain_free = start;
    end else begin
      run = 0;
      for (int p = 0; p <= lastnz; p++) begin
        v = blk[zz[p]];
        if (v == 0) begin
          run++;
        end else begin
          e.cyc  = start + p + 1;
          e.run  = run[3:0];
          e.sat  = (v > 32767) || (v < -32768);
          e.level = (v > 32767) ? 16'sd32767 : (v < -32768) ? -16'sd32768 : v[15:0];
          e.last = (p == lastnz);
          q.push_back(e);
          run = 0;
        end
      end
      drain_free = start + lastnz;
    end
  endtask

  task automatic check_cycle();
    pair_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      assert (out_valid === 1'b1 && out_run === e.run && out_level === e.level &&
              out_last === e.last && out_sat === e.sat)
      else begin
        errors++;
        $error("FAIL pair cyc=%0d observed v=%0b run=%0d lvl=%0d last=%0b sat=%0b expected v=1 run=%0d lvl=%0d last=%0b sat=%0b",
               cyc, out_valid, out_run, out_level, out_last, out_sat, e.run, e.level, e.last, e.sat);
      end
    end else begin
      checks++;
      assert (out_valid === 1'b0)
      else begin
        errors++;
        $error("FAIL idle cyc=%0d observed out_valid=%0b expected 0", cyc, out_valid);
      end
    end
  endtask

  task automatic tick(input logic v, input int c);
    in_valid = v;
    in_coef  = c;
    if (v) begin
      blk[fill_cnt] = c;
      if (fill_cnt == 15) schedule(cyc);
      fill_cnt = (fill_cnt + 1) % 16;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic send_block(input int gap);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, cur[i]);
      for (int g = 0; g < gap; g++) tick(1'b0, 0);
    end
  endtask

  task automatic clear_cur();
    for (int i = 0; i < 16; i++) cur[i] = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    assert (out_valid === 1'b0 && out_run === 4'd0 && out_level === 16'sd0 &&
            out_last === 1'b0 && out_sat === 1'b0)
    else begin
      errors++;
      $error("FAIL %s observed v=%0b run=%0d lvl=%0d last=%0b sat=%0b expected all 0",
             tag, out_valid, out_run, out_level, out_last, out_sat);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check_zero_outputs("async_reset");
    q.delete();
    fill_cnt = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    drain_free = cyc;
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);

    // raster[0]=5
    clear_cur(); cur[0] = 5;
    send_block(0); idle(20);

    // raster[15]=-3, raster[2]=7
    clear_cur(); cur[15] = -3; cur[2] = 7;
    send_block(0); idle(20);

    // all-zero block
    clear_cur();
    send_block(0); idle(20);

    // saturation both directions
    clear_cur(); cur[0] = 40000; cur[1] = -40000;
    send_block(0); idle(20);

    // three back-to-back all-ones blocks
    for (int i = 0; i < 16; i++) cur[i] = 1;
    send_block(0); send_block(0); send_block(0);
    idle(40);

    // gapped beats, mixed values
    for (int i = 0; i < 16; i++) cur[i] = (i % 3 == 0) ? 0 : int'($urandom_range(0, 200)) - 100;
    cur[13] = 70000;
    send_block(1); idle(20);

    // abort a partial block, then a fresh block
    for (int i = 0; i < 9; i++) tick(1'b1, 9);
    do_reset();
    clear_cur(); cur[4] = 2;
    send_block(0); idle(20);

    // reset in the middle of a drain
    for (int i = 0; i < 16; i++) cur[i] = 3;
    send_block(0); idle(4);
    do_reset();
    idle(20);

    // trailing block after the mid-drain reset
    clear_cur(); cur[5] = -1; cur[10] = 4;
    send_block(0);

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      tick(1'b0, 0);
      guard++;
    end
    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL drain_timeout observed pending=%0d expected 0", q.size());
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
